fetch_queue: RTL and testbench

Instruction queue between the 2-wide `fetch` stage and decode. Captures up to two instructions per cycle from fetch and presents up to two in program order to decode. Decouples fetch from decode stalls and produces the `stall` input that fetch consumes. Clears on branch redirect.

---
 rtl/fetch_queue.sv | 75 +++++++
 tb/tb_fetch_queue.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: 2-wide in-order instruction queue between fetch and decode, cleared on redirect.
// Define FETCHQ_BYPASS_EN to pass fetch straight to decode while the queue is empty.
module fetch_queue #(
  parameter int XLEN = 32,
  parameter int FETCH_W = 2,
  parameter int DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            flush,
  input  logic [FETCH_W-1:0]              in_valid,
  input  logic [FETCH_W-1:0][XLEN-1:0]    in_pc,
  input  logic [FETCH_W-1:0][XLEN-1:0]    in_instr,
  output logic                            in_stall,
  output logic [FETCH_W-1:0]              out_valid,
  output logic [FETCH_W-1:0][XLEN-1:0]    out_pc,
  output logic [FETCH_W-1:0][XLEN-1:0]    out_instr,
  input  logic                            dec_stall
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] mem_pc [DEPTH];
  logic [XLEN-1:0] mem_instr [DEPTH];
  logic [AW-1:0] head, tail, head1, tail1;
  logic [AW:0] count, wr_n, rd_n;
  logic [FETCH_W-1:0] c_valid, q_valid;
  logic [FETCH_W-1:0][XLEN-1:0] c_pc, c_instr;
  logic byp, wr_en;
  assign head1 = head + 1'b1;
  assign tail1 = tail + 1'b1;
  assign in_stall = count > (AW+1)'(DEPTH - 2);
  // A lone valid slot is always packed into slot 0
  assign c_valid = {&in_valid, |in_valid};
  assign c_pc = {in_pc[1], in_valid[0] ? in_pc[0] : in_pc[1]};
  assign c_instr = {in_instr[1], in_valid[0] ? in_instr[0] : in_instr[1]};
  assign q_valid = {count >= (AW+1)'(2), count != '0};
`ifdef FETCHQ_BYPASS_EN
  assign byp = (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif
  always_comb begin
    out_valid = byp ? c_valid : q_valid;
    out_pc[0] = !out_valid[0] ? '0 : byp ? c_pc[0] : mem_pc[head];
    out_pc[1] = !out_valid[1] ? '0 : byp ? c_pc[1] : mem_pc[head1];
    out_instr[0] = !out_valid[0] ? '0 : byp ? c_instr[0] : mem_instr[head];
    out_instr[1] = !out_valid[1] ? '0 : byp ? c_instr[1] : mem_instr[head1];
  end
  // Bypassed instructions consumed by decode never enter storage
  assign wr_en = !in_stall && !flush && !(byp && !dec_stall);
  assign wr_n = !wr_en ? '0 : c_valid[1] ? (AW+1)'(2) : (AW+1)'(c_valid[0]);
  assign rd_n = dec_stall ? '0 : q_valid[1] ? (AW+1)'(2) : (AW+1)'(q_valid[0]);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + rd_n[AW-1:0];
      tail <= tail + wr_n[AW-1:0];
      count <= count + wr_n - rd_n;
    end
  always_ff @(posedge clk)
    if (wr_n != '0) begin
      mem_pc[tail] <= c_pc[0];
      mem_instr[tail] <= c_instr[0];
      if (c_valid[1]) begin
        mem_pc[tail1] <= c_pc[1];
        mem_instr[tail1] <= c_instr[1];
      end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenario tests for fetch_queue (DEPTH 8, default build).
module tb_fetch_queue;
  logic clk = 1'b0;
  logic reset, flush, in_stall, dec_stall;
  logic [1:0] in_valid, out_valid;
  logic [1:0][31:0] in_pc, in_instr, out_pc, out_instr;
  int passed = 0, total = 0;

  fetch_queue #(.XLEN(32), .FETCH_W(2), .DEPTH(8)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
    .in_stall(in_stall),
    .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
    .dec_stall(dec_stall)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] p1);
    in_valid = v;
    in_pc[0] = p0;
    in_pc[1] = p1;
    in_instr[0] = ~p0;
    in_instr[1] = ~p1;
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; dec_stall = 1'b0;
    put(2'b00, 32'h0, 32'h0);
    #12;
    total++; if (out_valid !== 2'b00) $display("FAIL reset_valid got %b want 00", out_valid); else passed++;
    total++; if (in_stall !== 1'b0) $display("FAIL reset_stall got %b want 0", in_stall); else passed++;
    total++; if (out_pc !== 64'h0 || out_instr !== 64'h0) $display("FAIL reset_data got %h/%h want 0", out_pc, out_instr); else passed++;
    reset = 1'b1;
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL reset_release got %b want 00", out_valid); else passed++;
  endtask

  task automatic test_streaming();
    dec_stall = 1'b0;
    for (int k = 0; k < 6; k++) begin
      put(2'b11, 32'(8 * k), 32'(8 * k + 4));
      step();
      total++;
      if (out_valid !== 2'b11 || out_pc[0] !== 32'(8 * k) || out_pc[1] !== 32'(8 * k + 4))
        $display("FAIL stream k=%0d got %b %h/%h want 11 %h/%h", k, out_valid, out_pc[0], out_pc[1], 8 * k, 8 * k + 4);
      else passed++;
      total++; if (out_instr[1] !== ~32'(8 * k + 4)) $display("FAIL stream_instr k=%0d got %h want %h", k, out_instr[1], ~32'(8 * k + 4)); else passed++;
      total++; if (in_stall !== 1'b0) $display("FAIL stream_stall k=%0d got %b want 0", k, in_stall); else passed++;
    end
    put(2'b00, 32'h0, 32'h0);
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL stream_drain got %b want 00", out_valid); else passed++;
  endtask

  task automatic test_fill();
    int k;
    logic st;
    logic [31:0] nxt;
    dec_stall = 1'b1;
    k = 0;
    for (int s = 1; s <= 7; s++) begin
      put(2'b11, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k));
      st = in_stall;
      step();
      if (!st) k++;
      total++; if (in_stall !== 1'(s >= 4)) $display("FAIL fill_stall s=%0d got %b want %b", s, in_stall, s >= 4); else passed++;
    end
    total++; if (k != 4) $display("FAIL fill_accepted got %0d want 4", k); else passed++;
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h100) $display("FAIL fill_head got %b %h want 11 100", out_valid, out_pc[0]); else passed++;
    dec_stall = 1'b0;
    nxt = 32'h100;
    for (int c = 0; c < 30; c++) begin
      if (out_valid[0]) begin
        total++; if (out_pc[0] !== nxt) $display("FAIL fill_order0 c=%0d got %h want %h", c, out_pc[0], nxt); else passed++;
        nxt += 4;
      end
      if (out_valid[1]) begin
        total++; if (out_pc[1] !== nxt) $display("FAIL fill_order1 c=%0d got %h want %h", c, out_pc[1], nxt); else passed++;
        nxt += 4;
      end
      put(k < 11 ? 2'b11 : 2'b00, 32'h100 + 32'(8 * k), 32'h104 + 32'(8 * k));
      st = in_stall;
      step();
      if (!st && k < 11) k++;
      if (c == 0) begin
        total++; if (k != 4) $display("FAIL fill_hold got %0d want 4", k); else passed++;
      end
      if (c == 1) begin
        total++; if (k != 5) $display("FAIL fill_resume got %0d want 5", k); else passed++;
      end
    end
    total++; if (nxt !== 32'h158) $display("FAIL fill_total got %h want 158", nxt); else passed++;
    total++; if (out_valid !== 2'b00 || in_stall !== 1'b0) $display("FAIL fill_empty got %b/%b want 00/0", out_valid, in_stall); else passed++;
  endtask

  task automatic test_compaction();
    dec_stall = 1'b1;
    put(2'b10, 32'h5555_5555, 32'h14);
    step();
    total++; if (out_valid !== 2'b01 || out_pc[0] !== 32'h14 || out_pc[1] !== 32'h0) $display("FAIL comp_single got %b %h/%h want 01 14/0", out_valid, out_pc[0], out_pc[1]); else passed++;
    total++; if (out_instr[0] !== ~32'h14) $display("FAIL comp_instr got %h want %h", out_instr[0], ~32'h14); else passed++;
    put(2'b11, 32'h18, 32'h1C);
    step();
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h14 || out_pc[1] !== 32'h18) $display("FAIL comp_pair got %b %h/%h want 11 14/18", out_valid, out_pc[0], out_pc[1]); else passed++;
    put(2'b00, 32'h0, 32'h0);
    dec_stall = 1'b0;
    step();
    total++; if (out_valid !== 2'b01 || out_pc[0] !== 32'h1C || out_pc[1] !== 32'h0) $display("FAIL comp_tail got %b %h/%h want 01 1c/0", out_valid, out_pc[0], out_pc[1]); else passed++;
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL comp_empty got %b want 00", out_valid); else passed++;
  endtask

  task automatic test_flush();
    dec_stall = 1'b1;
    put(2'b11, 32'h200, 32'h204); step();
    put(2'b11, 32'h208, 32'h20C); step();
    put(2'b01, 32'h210, 32'h0); step();
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h200 || in_stall !== 1'b0) $display("FAIL flush_pre got %b %h %b want 11 200 0", out_valid, out_pc[0], in_stall); else passed++;
    flush = 1'b1;
    put(2'b11, 32'h300, 32'h304);
    step();
    total++; if (out_valid !== 2'b00 || in_stall !== 1'b0) $display("FAIL flush_clear got %b/%b want 00/0", out_valid, in_stall); else passed++;
    flush = 1'b0;
    dec_stall = 1'b0;
    put(2'b11, 32'h08, 32'h0C);
    step();
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h08 || out_pc[1] !== 32'h0C) $display("FAIL flush_redirect got %b %h/%h want 11 08/0c", out_valid, out_pc[0], out_pc[1]); else passed++;
    put(2'b00, 32'h0, 32'h0);
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL flush_drop got %b want 00", out_valid); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] nxt;
    dec_stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      put(2'b01, 32'h400 + 32'(4 * i), 32'h0);
      step();
      total++; if (out_valid !== 2'b01 || out_pc[0] !== 32'h400 + 32'(4 * i)) $display("FAIL wrap_offset i=%0d got %b %h want 01 %h", i, out_valid, out_pc[0], 32'h400 + 32'(4 * i)); else passed++;
    end
    put(2'b00, 32'h0, 32'h0);
    step();
    nxt = 32'h500;
    for (int c = 0; c < 28; c++) begin
      if (out_valid[0]) begin
        total++; if (out_pc[0] !== nxt) $display("FAIL wrap_order0 c=%0d got %h want %h", c, out_pc[0], nxt); else passed++;
        nxt += 4;
      end
      if (out_valid[1]) begin
        total++; if (out_pc[1] !== nxt) $display("FAIL wrap_order1 c=%0d got %h want %h", c, out_pc[1], nxt); else passed++;
        nxt += 4;
      end
      total++; if (in_stall !== 1'b0) $display("FAIL wrap_stall c=%0d got %b want 0", c, in_stall); else passed++;
      put(c < 24 ? 2'b11 : 2'b00, 32'h500 + 32'(8 * c), 32'h504 + 32'(8 * c));
      step();
    end
    total++; if (nxt !== 32'h5C0) $display("FAIL wrap_total got %h want 5c0", nxt); else passed++;
  endtask

  task automatic test_reset_mid();
    dec_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      put(2'b11, 32'h700 + 32'(8 * i), 32'h704 + 32'(8 * i));
      step();
    end
    put(2'b00, 32'h0, 32'h0);
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h700 || in_stall !== 1'b0) $display("FAIL rmid_pre got %b %h %b want 11 700 0", out_valid, out_pc[0], in_stall); else passed++;
    #3 reset = 1'b0;
    #1;
    total++; if (out_valid !== 2'b00 || in_stall !== 1'b0) $display("FAIL rmid_async got %b/%b want 00/0", out_valid, in_stall); else passed++;
    total++; if (out_pc !== 64'h0) $display("FAIL rmid_data got %h want 0", out_pc); else passed++;
    #2 reset = 1'b1;
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL rmid_discard got %b want 00", out_valid); else passed++;
    dec_stall = 1'b0;
    put(2'b11, 32'h600, 32'h604);
    step();
    total++; if (out_valid !== 2'b11 || out_pc[0] !== 32'h600 || out_pc[1] !== 32'h604) $display("FAIL rmid_first got %b %h/%h want 11 600/604", out_valid, out_pc[0], out_pc[1]); else passed++;
    put(2'b00, 32'h0, 32'h0);
    step();
    total++; if (out_valid !== 2'b00) $display("FAIL rmid_empty got %b want 00", out_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_fill();
    test_compaction();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
